mux_2x1_arbiter: RTL

- Two-requester round-robin arbiter that owns the select line of a shared 2:1 data mux and registers the selected data onto a single output channel.
- Sits between two producers (port 0, port 1) and one downstream consumer.
- Sequences mux ownership with req/gnt handshakes and a bounded hold time, so neither producer starves the other.

---
 rtl/mux_2x1_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_arbiter: two-requester round-robin arbiter that owns the select of a
// shared 2:1 data mux and registers the selected data onto one output channel.
// An owner holds the mux for at most MAX_HOLD consecutive cycles while the other
// requester waits. An uncontested owner may hold it indefinitely.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   req0   in   requester 0 wants the mux
//   req1   in   requester 1 wants the mux
//   i0     in   [DW] requester 0 data
//   i1     in   [DW] requester 1 data
//   gnt0   out  requester 0 owns the mux (registered)
//   gnt1   out  requester 1 owns the mux (registered)
//   s      out  mux select, 0 -> i0, 1 -> i1 (registered)
//   y      out  [DW] registered mux output
//   y_vld  out  y holds granted data this cycle
module mux_2x1_arbiter #(
   parameter int unsigned DW       = 1,
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CW       = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          s,
   output logic [DW-1:0] y,
   output logic          y_vld
);

   // Last hold count before a contested owner must hand over.
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            last_q, last_d;
   logic            s_q, s_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;
   logic [DW-1:0]   y_q;
   logic            y_vld_q;

   // State register and all registered outputs.
   // The data path samples the select and grants from the previous cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         last_q     <= 1'b1;
         s_q        <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         y_q        <= '0;
         y_vld_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         s_q        <= s_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         y_vld_q    <= gnt0_q | gnt1_q;
         if (gnt0_q | gnt1_q) begin
            y_q <= s_q ? i1 : i0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               // A tie goes to port 0 when port 1 was the last owner.
               state_d = last_q ? G0 : G1;
            end else if (req0) begin
               state_d = G0;
            end else if (req1) begin
               state_d = G1;
            end
         end
         G0: begin
            if (!req0) begin
               state_d = req1 ? G1 : IDLE;
            end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
               state_d = G1;
            end
         end
         G1: begin
            if (!req1) begin
               state_d = req0 ? G0 : IDLE;
            end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
               state_d = G0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, hold counter and tie-break bit.
   always_comb begin
      hold_cnt_d = '0;
      last_d     = last_q;
      s_d        = s_q;
      gnt0_d     = (state_d == G0);
      gnt1_d     = (state_d == G1);

      // Saturating at HOLD_LAST lets an uncontested owner stay indefinitely.
      // Once the other side requests, the owner hands over on the next edge.
      if ((state_d != IDLE) && (state_d == state_q)) begin
         hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CW'(1);
      end

      // The select and tie-break bit change only on entry into a grant state.
      // The select holds its value through IDLE.
      if ((state_d != state_q) && (state_d == G0)) begin
         last_d = 1'b0;
         s_d    = 1'b0;
      end else if ((state_d != state_q) && (state_d == G1)) begin
         last_d = 1'b1;
         s_d    = 1'b1;
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign s     = s_q;
   assign y     = y_q;
   assign y_vld = y_vld_q;

endmodule
